boid_frame_writer: RTL and testbench

BOID_FRAME_WRITER -- requirements
Module: boid_frame_writer

---
 rtl/boid_pkg.sv | 27 ++
 rtl/boid_sprite_walker.sv | 59 +++++
 rtl/boid_frame_writer.sv | 209 ++++++++++++++++++++
 tb/tb_boid_frame_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boid_pkg.sv
// Shared constants, FSM encoding and helpers for the boid frame writer.
package boid_pkg;

   localparam int VIDEO_WIDTH         = 640;
   localparam int VIDEO_HEIGHT        = 480;
   localparam int PIXEL_COUNT         = VIDEO_WIDTH * VIDEO_HEIGHT;
   localparam int PIXEL_ADDRESS_WIDTH = $clog2(PIXEL_COUNT) + 1;
   localparam int MAX_BOIDS           = 32;
   localparam int BITS_FOR_BOIDS      = $clog2(MAX_BOIDS);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ERASE = 2'd1,
      ST_DRAW  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Largest sprite offset that still lands on screen for an in-bounds anchor.
   function automatic logic [1:0] edge_limit(input int pos, input int size, input int sprite);
      int room;
      room = size - 1 - pos;
      if (room < 0) room = 0;
      if (room > sprite - 1) room = sprite - 1;
      return 2'(room);
   endfunction

endpackage

// File: rtl/boid_sprite_walker.sv
// Raster scan over one SPRITE x SPRITE square: produces the pixel address,
// a clip flag from per-axis offset limits, and first/last markers.
module boid_sprite_walker #(
   parameter int SPRITE      = 2,
   parameter int VIDEO_WIDTH = 640,
   parameter int AW          = 20
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          run_i,
   input  logic [AW-1:0] base_i,
   input  logic [1:0]    xlim_i,
   input  logic [1:0]    ylim_i,
   output logic          first_o,
   output logic          last_o,
   output logic          clip_o,
   output logic [AW-1:0] addr_o
);

   localparam logic [1:0] S_MAX = 2'(SPRITE - 1);

   logic [1:0] dx_q, dx_d;
   logic [1:0] dy_q, dy_d;

   // Advance dx fastest, wrapping into dy; park at origin when idle.
   always_comb begin
      dx_d = dx_q;
      dy_d = dy_q;
      if (!run_i) begin
         dx_d = '0;
         dy_d = '0;
      end else if (dx_q == S_MAX) begin
         dx_d = '0;
         dy_d = (dy_q == S_MAX) ? 2'd0 : dy_q + 2'd1;
      end else begin
         dx_d = dx_q + 2'd1;
      end
   end

   // Scan position registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dx_q <= '0;
         dy_q <= '0;
      end else begin
         dx_q <= dx_d;
         dy_q <= dy_d;
      end
   end

   // Per-pixel flags and address.
   always_comb begin
      first_o = (dx_q == 2'd0) && (dy_q == 2'd0);
      last_o  = (dx_q == S_MAX) && (dy_q == S_MAX);
      clip_o  = (dx_q > xlim_i) || (dy_q > ylim_i);
      addr_o  = base_i + AW'(int'(dx_q) + VIDEO_WIDTH * int'(dy_q));
   end

endmodule

// File: rtl/boid_frame_writer.sv
// Erases last frame's boid sprites, then draws the current ones into display RAM.
// Optional macro BOID_COLOR_EN: pix_data becomes COLOR_W wide with per-boid colour.
//
// state    | meaning
// IDLE     | waiting for frame_end
// ERASE    | walk every table slot, zero sprites that were drawn last frame
// DRAW     | read boids 0..count-1, draw sprites, record anchors
// DONE     | single cycle, frame_done high
module boid_frame_writer #(
   parameter int MAX_BOIDS    = boid_pkg::MAX_BOIDS,
   parameter int VIDEO_WIDTH  = boid_pkg::VIDEO_WIDTH,
   parameter int VIDEO_HEIGHT = boid_pkg::VIDEO_HEIGHT,
   parameter int SPRITE       = 2,
   parameter int COLOR_W      = 4
) (
   input  logic                                     clock,
   input  logic                                     resetn,
   input  logic                                     frame_end,
   input  logic [$clog2(MAX_BOIDS):0]               num_boids,
   output logic [$clog2(MAX_BOIDS)-1:0]             boid_sel,
   input  logic [9:0]                               boid_x,
   input  logic [8:0]                               boid_y,
   output logic                                     pix_we,
   output logic [$clog2(VIDEO_WIDTH*VIDEO_HEIGHT):0] pix_addr,
`ifdef BOID_COLOR_EN
   output logic [COLOR_W-1:0]                       pix_data,
`else
   output logic                                     pix_data,
`endif
   output logic                                     busy,
   output logic                                     frame_done,
   output logic                                     overrun
);

   import boid_pkg::*;

   localparam int BB = $clog2(MAX_BOIDS);
   localparam int CW = BB + 1;
   localparam int AW = $clog2(VIDEO_WIDTH * VIDEO_HEIGHT) + 1;

   state_t         state_q, state_d;
   logic [BB-1:0]  idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           overrun_q;

   logic           tbl_vld_q  [MAX_BOIDS];
   logic [AW-1:0]  tbl_addr_q [MAX_BOIDS];
   logic [1:0]     tbl_xl_q   [MAX_BOIDS];
   logic [1:0]     tbl_yl_q   [MAX_BOIDS];

   logic           anc_ok_q;
   logic [AW-1:0]  anc_addr_q;
   logic [1:0]     anc_xl_q, anc_yl_q;

   logic           live_ok;
   logic [AW-1:0]  live_addr;
   logic [1:0]     live_xl, live_yl;

   logic           w_run, w_first, w_last, w_clip, src_ok;
   logic [AW-1:0]  w_base, w_addr;
   logic [1:0]     w_xl, w_yl;

   // Anchor of the boid currently on boid_sel; address kept at full width.
   always_comb begin
      live_ok   = (int'(boid_x) < VIDEO_WIDTH) && (int'(boid_y) < VIDEO_HEIGHT);
      live_addr = AW'(int'(boid_x) + VIDEO_WIDTH * int'(boid_y));
      live_xl   = edge_limit(int'(boid_x), VIDEO_WIDTH, SPRITE);
      live_yl   = edge_limit(int'(boid_y), VIDEO_HEIGHT, SPRITE);
   end

   // Walker source: table entry in ERASE, live anchor on a boid's first DRAW cycle, latched after.
   always_comb begin
      w_run  = (state_q == ST_ERASE) || (state_q == ST_DRAW);
      w_base = anc_addr_q;
      w_xl   = anc_xl_q;
      w_yl   = anc_yl_q;
      src_ok = anc_ok_q;
      if (state_q == ST_ERASE) begin
         w_base = tbl_addr_q[idx_q];
         w_xl   = tbl_xl_q[idx_q];
         w_yl   = tbl_yl_q[idx_q];
         src_ok = tbl_vld_q[idx_q];
      end else if (w_first) begin
         w_base = live_addr;
         w_xl   = live_xl;
         w_yl   = live_yl;
         src_ok = live_ok;
      end
   end

   boid_sprite_walker #(
      .SPRITE      (SPRITE),
      .VIDEO_WIDTH (VIDEO_WIDTH),
      .AW          (AW)
   ) u_walker (
      .clock   (clock),
      .resetn  (resetn),
      .run_i   (w_run),
      .base_i  (w_base),
      .xlim_i  (w_xl),
      .ylim_i  (w_yl),
      .first_o (w_first),
      .last_o  (w_last),
      .clip_o  (w_clip),
      .addr_o  (w_addr)
   );

   // Next state, slot index and latched boid count.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (frame_end) begin
               state_d = ST_ERASE;
               idx_d   = '0;
               cnt_d   = (num_boids > CW'(MAX_BOIDS)) ? CW'(MAX_BOIDS) : num_boids;
            end
         end
         ST_ERASE: begin
            if (w_last) begin
               if (idx_q == BB'(MAX_BOIDS - 1)) begin
                  idx_d   = '0;
                  state_d = (cnt_q == '0) ? ST_DONE : ST_DRAW;
               end else begin
                  idx_d = idx_q + BB'(1);
               end
            end
         end
         ST_DRAW: begin
            if (w_last) begin
               if (CW'(idx_q) + CW'(1) == cnt_q) begin
                  idx_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + BB'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and control registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         overrun_q <= frame_end && (state_q != ST_IDLE);
      end
   end

   // Anchor table: a slot is invalidated once erased and rewritten only if drawn,
   // so slots beyond the new count stay invalid and are erased exactly once.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < MAX_BOIDS; i++) begin
            tbl_vld_q[i]  <= 1'b0;
            tbl_addr_q[i] <= '0;
            tbl_xl_q[i]   <= '0;
            tbl_yl_q[i]   <= '0;
         end
         anc_ok_q   <= 1'b0;
         anc_addr_q <= '0;
         anc_xl_q   <= '0;
         anc_yl_q   <= '0;
      end else begin
         if (state_q == ST_ERASE && w_last) begin
            tbl_vld_q[idx_q] <= 1'b0;
         end
         if (state_q == ST_DRAW && w_first) begin
            tbl_vld_q[idx_q]  <= live_ok;
            tbl_addr_q[idx_q] <= live_addr;
            tbl_xl_q[idx_q]   <= live_xl;
            tbl_yl_q[idx_q]   <= live_yl;
            anc_ok_q          <= live_ok;
            anc_addr_q        <= live_addr;
            anc_xl_q          <= live_xl;
            anc_yl_q          <= live_yl;
         end
      end
   end

   // Output decode; everything is quiet outside ERASE/DRAW.
   always_comb begin
      busy       = (state_q != ST_IDLE);
      frame_done = (state_q == ST_DONE);
      overrun    = overrun_q;
      boid_sel   = idx_q;
      pix_we     = w_run && src_ok && !w_clip;
      pix_addr   = w_run ? w_addr : '0;
      pix_data   = '0;
      if (state_q == ST_DRAW) begin
`ifdef BOID_COLOR_EN
         pix_data = COLOR_W'((int'(idx_q) % ((1 << COLOR_W) - 1)) + 1);
`else
         pix_data = 1'b1;
`endif
      end
   end

endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed bench: a 32-slot SPRITE=1 instance for sequencing and a 4-slot
// SPRITE=2 instance for clipping and multi-pixel addressing.
module tb_boid_frame_writer;

`ifdef BOID_COLOR_EN
   localparam int DW = 4;
`else
   localparam int DW = 1;
`endif

   logic clock = 1'b0;
   always #5 clock = ~clock;
   logic resetn;

   int total = 0;
   int bad   = 0;

   // instance 1: MAX_BOIDS=32, SPRITE=1
   logic          fe1;
   logic [5:0]    num1;
   logic [4:0]    sel1;
   logic [9:0]    bx1;
   logic [8:0]    by1;
   logic          we1, busy1, done1, ovr1;
   logic [19:0]   addr1;
   logic [DW-1:0] data1;
   int xs1 [32];
   int ys1 [32];

   // instance 2: MAX_BOIDS=4, SPRITE=2
   logic          fe2;
   logic [2:0]    num2;
   logic [1:0]    sel2;
   logic [9:0]    bx2;
   logic [8:0]    by2;
   logic          we2, busy2, done2, ovr2;
   logic [19:0]   addr2;
   logic [DW-1:0] data2;
   int xs2 [4];
   int ys2 [4];

   always_comb begin
      bx1 = 10'(xs1[sel1]);
      by1 = 9'(ys1[sel1]);
      bx2 = 10'(xs2[sel2]);
      by2 = 9'(ys2[sel2]);
   end

   boid_frame_writer #(.MAX_BOIDS(32), .SPRITE(1)) u_dut1 (
      .clock(clock), .resetn(resetn), .frame_end(fe1), .num_boids(num1),
      .boid_sel(sel1), .boid_x(bx1), .boid_y(by1), .pix_we(we1),
      .pix_addr(addr1), .pix_data(data1), .busy(busy1),
      .frame_done(done1), .overrun(ovr1)
   );

   boid_frame_writer #(.MAX_BOIDS(4), .SPRITE(2)) u_dut2 (
      .clock(clock), .resetn(resetn), .frame_end(fe2), .num_boids(num2),
      .boid_sel(sel2), .boid_x(bx2), .boid_y(by2), .pix_we(we2),
      .pix_addr(addr2), .pix_data(data2), .busy(busy2),
      .frame_done(done2), .overrun(ovr2)
   );

   int bcnt1, dcnt1, ocnt1, badwe1;
   int wa1 [$];
   int wd1 [$];
   int bcnt2, nwe2;
   int wa2 [$];
   int wd2 [$];

   always @(negedge clock) begin
      if (busy1) bcnt1++;
      if (done1) dcnt1++;
      if (ovr1)  ocnt1++;
      if (we1 && (!busy1 || done1)) badwe1++;
      if (we1) begin
         wa1.push_back(int'(addr1));
         wd1.push_back(int'(data1));
      end
      if (busy2) bcnt2++;
      if (busy2 && !we2) nwe2++;
      if (we2) begin
         wa2.push_back(int'(addr2));
         wd2.push_back(int'(data2));
      end
   end

   function automatic int exp_data(input int i);
`ifdef BOID_COLOR_EN
      return (i % 15) + 1;
`else
      return 1;
`endif
   endfunction

   function automatic int qget(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   function automatic int zeros(input int q[$]);
      int n = 0;
      foreach (q[i]) if (q[i] == 0) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input longint obs, input longint exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic clr1();
      bcnt1 = 0; dcnt1 = 0; ocnt1 = 0; badwe1 = 0;
      wa1.delete(); wd1.delete();
   endtask

   task automatic clr2();
      bcnt2 = 0; nwe2 = 0;
      wa2.delete(); wd2.delete();
   endtask

   task automatic wait1(input string tag);
      bit to = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (!busy1) begin
            to = 1'b0;
            break;
         end
         tick(1);
      end
      chk(tag, to, 0);
   endtask

   task automatic frame1(input string tag);
      clr1();
      fe1 = 1'b1; tick(1); fe1 = 1'b0;
      wait1(tag);
      tick(1);
   endtask

   task automatic frame2(input string tag);
      bit to = 1'b1;
      clr2();
      fe2 = 1'b1; tick(1); fe2 = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (!busy2) begin
            to = 1'b0;
            break;
         end
         tick(1);
      end
      chk(tag, to, 0);
      tick(1);
   endtask

   initial begin
      resetn = 1'b0; fe1 = 1'b0; fe2 = 1'b0; num1 = '0; num2 = '0;
      for (int i = 0; i < 32; i++) begin xs1[i] = 0; ys1[i] = 0; end
      for (int i = 0; i < 4; i++)  begin xs2[i] = 0; ys2[i] = 0; end
      clr1(); clr2();
      tick(3);

      chk("rst_busy", busy1, 0);
      chk("rst_we", we1, 0);
      chk("rst_addr", addr1, 0);
      chk("rst_data", data1, 0);
      chk("rst_done", done1, 0);
      chk("rst_ovr", ovr1, 0);
      chk("rst_sel", sel1, 0);
      chk("rst_busy2", busy2, 0);
      resetn = 1'b1;
      tick(2);

      // corner boid, 2x2 sprite: three pixels clipped
      num2 = 3'd1; xs2[0] = 639; ys2[0] = 479;
      frame2("clip_timeout");
      chk("clip_nwrites", wa2.size(), 1);
      chk("clip_addr", qget(wa2, 0), 307199);
      chk("clip_data", qget(wd2, 0), exp_data(0));
      chk("clip_quiet_cycles", nwe2, 20);
      chk("clip_busy", bcnt2, 21);

      // erase the corner pixel, draw a full 2x2 at origin
      xs2[0] = 0; ys2[0] = 0;
      frame2("sq_timeout");
      chk("sq_nwrites", wa2.size(), 5);
      chk("sq_erase_addr", qget(wa2, 0), 307199);
      chk("sq_erase_data", qget(wd2, 0), 0);
      chk("sq_px0", qget(wa2, 1), 0);
      chk("sq_px1", qget(wa2, 2), 1);
      chk("sq_px2", qget(wa2, 3), 640);
      chk("sq_px3", qget(wa2, 4), 641);

      // first frame after reset, single boid
      num1 = 6'd1; xs1[0] = 10; ys1[0] = 5;
      frame1("f1_timeout");
      chk("f1_nwrites", wa1.size(), 1);
      chk("f1_addr", qget(wa1, 0), 3210);
      chk("f1_data", qget(wd1, 0), exp_data(0));
      chk("f1_done", dcnt1, 1);
      chk("f1_busy", bcnt1, 34);

      // boid moves one pixel right
      xs1[0] = 11;
      frame1("f2_timeout");
      chk("f2_nwrites", wa1.size(), 2);
      chk("f2_erase_addr", qget(wa1, 0), 3210);
      chk("f2_erase_data", qget(wd1, 0), 0);
      chk("f2_draw_addr", qget(wa1, 1), 3211);
      chk("f2_draw_data", qget(wd1, 1), exp_data(0));

      // three boids
      num1 = 6'd3;
      xs1[0] = 0; ys1[0] = 0; xs1[1] = 100; ys1[1] = 200; xs1[2] = 639; ys1[2] = 0;
      frame1("f3_timeout");
      chk("f3_nwrites", wa1.size(), 4);
      chk("f3_b1_addr", qget(wa1, 2), 128100);
      chk("f3_b2_addr", qget(wa1, 3), 639);
      chk("f3_busy", bcnt1, 36);

      // count drops to one
      num1 = 6'd1; xs1[0] = 1; ys1[0] = 1;
      frame1("f4_timeout");
      chk("f4_nwrites", wa1.size(), 4);
      chk("f4_erases", zeros(wd1), 3);
      chk("f4_draw_addr", qget(wa1, 3), 641);
      chk("f4_busy", bcnt1, 34);

      // next frame only touches the one remaining boid
      frame1("f5_timeout");
      chk("f5_nwrites", wa1.size(), 2);
      chk("f5_erase_addr", qget(wa1, 0), 641);

      // both boids off screen
      num1 = 6'd2; xs1[0] = 640; ys1[0] = 0; xs1[1] = 0; ys1[1] = 480;
      frame1("f6_timeout");
      chk("f6_nwrites", wa1.size(), 1);
      chk("f6_busy", bcnt1, 35);

      // zero count: nothing stored last frame, no draw cycles
      num1 = 6'd0;
      frame1("f7_timeout");
      chk("f7_nwrites", wa1.size(), 0);
      chk("f7_busy", bcnt1, 33);

      // count above MAX_BOIDS clamps to 32
      num1 = 6'd40;
      for (int i = 0; i < 32; i++) begin xs1[i] = i; ys1[i] = 0; end
      frame1("f8_timeout");
      chk("f8_busy", bcnt1, 65);
      chk("f8_nwrites", wa1.size(), 32);
      chk("f8_b15_addr", qget(wa1, 15), 15);
      chk("f8_b15_data", qget(wd1, 15), exp_data(15));

      // frame_end while busy: dropped, overrun pulses once
      num1 = 6'd1; xs1[0] = 10; ys1[0] = 5;
      clr1();
      fe1 = 1'b1; tick(1); fe1 = 1'b0;
      tick(3);
      fe1 = 1'b1; tick(1); fe1 = 1'b0;
      wait1("ovr_timeout");
      tick(10);
      chk("ovr_pulses", ocnt1, 1);
      chk("ovr_done", dcnt1, 1);
      chk("ovr_busy", bcnt1, 34);
      chk("ovr_nwrites", wa1.size(), 33);

      // reset in the middle of DRAW
      num1 = 6'd16;
      for (int i = 0; i < 32; i++) begin xs1[i] = i + 20; ys1[i] = 1; end
      clr1();
      fe1 = 1'b1; tick(1); fe1 = 1'b0;
      tick(36);
      chk("mid_busy_before", busy1, 1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_busy", busy1, 0);
      chk("mid_rst_we", we1, 0);
      chk("mid_rst_sel", sel1, 0);
      tick(2);
      resetn = 1'b1;
      tick(1);
      frame1("f9_timeout");
      chk("f9_nwrites", wa1.size(), 16);
      chk("f9_erases", zeros(wd1), 0);
      chk("f9_b15_addr", qget(wa1, 15), 675);
      chk("f9_b15_data", qget(wd1, 15), exp_data(15));
      chk("f9_we_outside", badwe1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
